// File: rtl/bubble_buffer_loader.sv
// rtl/bubble_buffer_loader.sv - fetches ROM bytes and unpacks them into 2-bit bubble buffer words
module bubble_buffer_loader #(
    parameter int PAGE_WORDS = 584,
    parameter int BOOT_WORDS = 2048
) (
    input  logic        master_clock,
    input  logic        power_good,
    input  logic        loader_enable,
    input  logic        load_page,
    input  logic        load_bootloader,
    input  logic [2:0]  image_number,
    input  logic [11:0] current_page,
    output logic [24:0] rom_address,
    output logic        rom_read_request,
    input  logic        rom_data_valid,
    input  logic [7:0]  rom_data_input,
    output logic [10:0] bubble_buffer_write_address,
    output logic [1:0]  bubble_buffer_write_data_input,
    output logic        bubble_buffer_write_enable,
    output logic        bubble_buffer_write_clock,
    output logic        loader_busy,
    output logic        load_done,
    output logic        load_overrun
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_STROBE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [10:0] PAGE_LAST = 11'(PAGE_WORDS - 1);
    localparam logic [10:0] BOOT_LAST = 11'(BOOT_WORDS - 1);

    logic [2:0]  state;
    logic        page_prev;
    logic        boot_prev;
    logic        edge_armed;
    logic        page_edge;
    logic        boot_edge;
    logic        any_edge;
    logic [2:0]  image_q;
    logic        boot_q;
    logic [11:0] page_q;
    logic [8:0]  byte_index;
    logic [1:0]  pair_idx;
    logic [7:0]  byte_q;
    logic [10:0] word_count;
    logic [10:0] last_word;
    logic        overrun_q;
    logic [1:0]  word_data;

    // edge_armed stays low for the first clock after reset so a request held
    // high across reset release is seeded into the previous-sample registers
    // instead of being mistaken for a fresh edge.
    assign page_edge = edge_armed & load_page & ~page_prev;
    assign boot_edge = edge_armed & load_bootloader & ~boot_prev;
    assign any_edge  = page_edge | boot_edge;

    always_ff @(posedge master_clock or negedge power_good) begin
        if (!power_good) begin
            state      <= ST_IDLE;
            page_prev  <= 1'b0;
            boot_prev  <= 1'b0;
            edge_armed <= 1'b0;
            image_q    <= 3'd0;
            boot_q     <= 1'b0;
            page_q     <= 12'd0;
            byte_index <= 9'd0;
            pair_idx   <= 2'd0;
            byte_q     <= 8'd0;
            word_count <= 11'd0;
            last_word  <= 11'd0;
            overrun_q  <= 1'b0;
        end else begin
            page_prev  <= load_page;
            boot_prev  <= load_bootloader;
            edge_armed <= 1'b1;
            if (any_edge && state != ST_IDLE) begin
                overrun_q <= 1'b1;
            end
            if (!loader_enable) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (any_edge) begin
                            // bootloader wins when both requests rise together
                            state      <= ST_FETCH;
                            image_q    <= image_number;
                            boot_q     <= boot_edge;
                            page_q     <= boot_edge ? 12'd0 : current_page;
                            last_word  <= boot_edge ? BOOT_LAST : PAGE_LAST;
                            byte_index <= 9'd0;
                            pair_idx   <= 2'd0;
                            word_count <= 11'd0;
                        end
                    end
                    ST_FETCH: begin
                        if (rom_data_valid) begin
                            byte_q <= rom_data_input;
                            state  <= ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        state <= ST_STROBE;
                    end
                    ST_STROBE: begin
                        // the final word does not advance the address, so it
                        // never wraps past 2047 and unused pairs are dropped
                        if (word_count == last_word) begin
                            state <= ST_DONE;
                        end else begin
                            word_count <= word_count + 11'd1;
                            if (pair_idx == 2'd3) begin
                                pair_idx   <= 2'd0;
                                byte_index <= byte_index + 9'd1;
                                state      <= ST_FETCH;
                            end else begin
                                pair_idx <= pair_idx + 2'd1;
                                state    <= ST_SETUP;
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        word_data = 2'b00;
        case (pair_idx)
            2'd0: word_data = byte_q[7:6];
            2'd1: word_data = byte_q[5:4];
            2'd2: word_data = byte_q[3:2];
            2'd3: word_data = byte_q[1:0];
            default: word_data = 2'b00;
        endcase
    end

    assign rom_address                    = {image_q, boot_q, page_q, byte_index};
    assign rom_read_request               = (state == ST_FETCH);
    assign bubble_buffer_write_address    = word_count;
    assign bubble_buffer_write_data_input = word_data;
    assign bubble_buffer_write_enable     = (state == ST_SETUP) || (state == ST_STROBE);
    assign bubble_buffer_write_clock      = (state == ST_STROBE);
    assign loader_busy                    = (state != ST_IDLE);
    assign load_done                      = (state == ST_DONE);
    assign load_overrun                   = overrun_q;

endmodule
